// File: rtl/x_hazard_unit.sv
// Purpose : X-stage hazard/forwarding controller with a NUM_FWD-deep write history, load-use stall and multi-cycle redirect flush.
// Latency : all outputs combinational from registered history/flush counter and current inputs; no added X-path latency.
// Backpr. : stall holds F/D/X while a needed load result is outstanding; flush kills F/D and X for FLUSH_CYCLES after a redirect.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   x_valid, x_inst, x_result    instruction occupying X and its non-load result
//   redirect                     X instruction is a taken branch / JAL / JALR
//   ld_resp_valid, ld_resp_data  load data returning this cycle
//   fwd_a_sel/fwd_b_sel          0 = register file, k = history entry k-1
//   fwd_a_data/fwd_b_data        forwarded operand value (0 when sel = 0)
//   stall, flush                 pipeline hold / kill
//   perf_stall_cnt/perf_flush_cnt  present only when X_HAZARD_PERF_EN is defined
//
// Optional feature macro: X_HAZARD_PERF_EN (stall and accepted-redirect counters).
// Legal parameter ranges: NUM_FWD 2..8, FLUSH_CYCLES 1..4; SEL_W is derived.

module x_hazard_unit #(
    parameter int XLEN         = 32,
    parameter int NUM_FWD      = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int SEL_W        = $clog2(NUM_FWD + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             x_valid,
    input  logic [31:0]      x_inst,
    input  logic [XLEN-1:0]  x_result,
    input  logic             redirect,
    input  logic             ld_resp_valid,
    input  logic [XLEN-1:0]  ld_resp_data,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic [XLEN-1:0]  fwd_a_data,
    output logic [XLEN-1:0]  fwd_b_data,
    output logic             stall,
    output logic             flush
`ifdef X_HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    // ------------------------------------------------------------------
    // Local types and constants
    // ------------------------------------------------------------------
    localparam int IDX_W = $clog2(NUM_FWD);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_CSRRW   = 3'b001;

    typedef struct packed {
        logic            vld;
        logic            pend;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } hist_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    hist_t            hist     [NUM_FWD];
    hist_t            hist_nxt [NUM_FWD];
    logic [CNT_W-1:0] flush_cnt;
    logic             flush_cnt_active;

    // ------------------------------------------------------------------
    // Decode of the instruction in X
    // ------------------------------------------------------------------
    logic [6:0] opc;
    logic [2:0] funct3;
    logic [4:0] rs1_raw;
    logic [4:0] rs2_raw;
    logic [4:0] rd_raw;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       is_load;
    logic [4:0] rs1_eff;
    logic [4:0] rs2_eff;

    // funct7 / upper immediate bits play no part in hazard detection
    logic unused_inst_hi;
    assign unused_inst_hi = &{1'b0, x_inst[31:25]};

    always_comb begin
        opc     = x_inst[6:0];
        funct3  = x_inst[14:12];
        rs1_raw = x_inst[19:15];
        rs2_raw = x_inst[24:20];
        rd_raw  = x_inst[11:7];

        uses_rs1 = (opc == OPC_R)     || (opc == OPC_IMM)    || (opc == OPC_LOAD) ||
                   (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR) ||
                   ((opc == OPC_SYSTEM) && (funct3 == F3_CSRRW));
        uses_rs2 = (opc == OPC_R) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
        writes_rd = (opc == OPC_R)    || (opc == OPC_IMM)  || (opc == OPC_LOAD) ||
                    (opc == OPC_JAL)  || (opc == OPC_JALR) || (opc == OPC_LUI)  ||
                    (opc == OPC_AUIPC);
        is_load  = (opc == OPC_LOAD);

        // An unused source collapses to x0, which never matches a history entry.
        rs1_eff = uses_rs1 ? rs1_raw : 5'd0;
        rs2_eff = uses_rs2 ? rs2_raw : 5'd0;
    end

    // ------------------------------------------------------------------
    // Load response target: the oldest pending entry in the current history
    // ------------------------------------------------------------------
    logic             any_pend;
    logic             resp_hit;
    logic [IDX_W-1:0] resp_idx;

    always_comb begin
        any_pend = 1'b0;
        resp_idx = '0;
        // Ascending scan: the last pending entry seen is the oldest.
        for (int i = 0; i < NUM_FWD; i++) begin
            if (hist[i].pend) begin
                any_pend = 1'b1;
                resp_idx = IDX_W'(i);
            end
        end
        resp_hit = ld_resp_valid && any_pend;
    end

    // ------------------------------------------------------------------
    // Forwarding lookup (youngest matching entry wins)
    // ------------------------------------------------------------------
    logic             a_hit, b_hit;
    logic [IDX_W-1:0] a_idx, b_idx;
    logic [XLEN-1:0]  a_dat, b_dat;
    logic             a_blk, b_blk;

    always_comb begin
        a_hit = 1'b0;
        a_idx = '0;
        a_dat = '0;
        a_blk = 1'b0;
        b_hit = 1'b0;
        b_idx = '0;
        b_dat = '0;
        b_blk = 1'b0;
        // Descending scan so younger matches overwrite older ones.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (hist[i].vld && (rs1_eff != 5'd0) && (hist[i].rd == rs1_eff)) begin
                a_hit = 1'b1;
                a_idx = IDX_W'(i);
                if (hist[i].pend && resp_hit && (resp_idx == IDX_W'(i))) begin
                    // Load data arrives just in time: bypass it straight through.
                    a_dat = ld_resp_data;
                    a_blk = 1'b0;
                end else begin
                    a_dat = hist[i].data;
                    a_blk = hist[i].pend;
                end
            end
            if (hist[i].vld && (rs2_eff != 5'd0) && (hist[i].rd == rs2_eff)) begin
                b_hit = 1'b1;
                b_idx = IDX_W'(i);
                if (hist[i].pend && resp_hit && (resp_idx == IDX_W'(i))) begin
                    b_dat = ld_resp_data;
                    b_blk = 1'b0;
                end else begin
                    b_dat = hist[i].data;
                    b_blk = hist[i].pend;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic live;
    logic redirect_acc;

    assign flush_cnt_active = (flush_cnt != '0);

    always_comb begin
        fwd_a_sel  = '0;
        fwd_b_sel  = '0;
        fwd_a_data = '0;
        fwd_b_data = '0;
        if (x_valid && a_hit) begin
            fwd_a_sel  = SEL_W'(a_idx) + SEL_W'(1);
            fwd_a_data = a_dat;
        end
        if (x_valid && b_hit) begin
            fwd_b_sel  = SEL_W'(b_idx) + SEL_W'(1);
            fwd_b_data = b_dat;
        end
    end

    // Stall does not depend on live, so there is no combinational loop via flush.
    assign stall        = x_valid && !flush_cnt_active &&
                          ((a_hit && a_blk) || (b_hit && b_blk));
    assign live         = x_valid && !flush_cnt_active && !stall;
    assign redirect_acc = redirect && live;
    assign flush        = redirect_acc || flush_cnt_active;

    // ------------------------------------------------------------------
    // Next history: shift by one, insert the X write (or a bubble) at 0,
    // then land any load response on the slot its entry shifts into.
    // ------------------------------------------------------------------
    always_comb begin
        hist_nxt[0] = '0;
        if (live && writes_rd && (rd_raw != 5'd0)) begin
            hist_nxt[0].vld  = 1'b1;
            hist_nxt[0].pend = is_load;
            hist_nxt[0].rd   = rd_raw;
            hist_nxt[0].data = is_load ? '0 : x_result;
        end
        for (int i = 1; i < NUM_FWD; i++) begin
            hist_nxt[i] = hist[i-1];
            if (resp_hit && (resp_idx == IDX_W'(i - 1))) begin
                hist_nxt[i].pend = 1'b0;
                hist_nxt[i].data = ld_resp_data;
            end
        end
        // A response for the oldest slot is consumed (and may have been
        // forwarded this cycle) but the entry itself falls off the end.
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_FWD; i++) begin
                hist[i] <= '0;
            end
            flush_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_FWD; i++) begin
                hist[i] <= hist_nxt[i];
            end
            if (redirect_acc) begin
                flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
            end else if (flush_cnt_active) begin
                flush_cnt <= flush_cnt - CNT_W'(1);
            end
        end
    end

`ifdef X_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_acc) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_x_hazard_unit.sv
// Purpose : directed, table-driven check of x_hazard_unit (forwarding, load-use stall, flush, reset).
// Latency : one table row per clock; inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpr. : none; all waits are fixed clock counts.

module tb_x_hazard_unit;

    localparam int XLEN  = 32;
    localparam int SEL_W = 2;

    logic             clk;
    logic             reset_n;
    logic             x_valid;
    logic [31:0]      x_inst;
    logic [XLEN-1:0]  x_result;
    logic             redirect;
    logic             ld_resp_valid;
    logic [XLEN-1:0]  ld_resp_data;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic [XLEN-1:0]  fwd_a_data;
    logic [XLEN-1:0]  fwd_b_data;
    logic             stall;
    logic             flush;
`ifdef X_HAZARD_PERF_EN
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_flush_cnt;
`endif

    x_hazard_unit #(
        .XLEN         (XLEN),
        .NUM_FWD      (2),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .x_valid       (x_valid),
        .x_inst        (x_inst),
        .x_result      (x_result),
        .redirect      (redirect),
        .ld_resp_valid (ld_resp_valid),
        .ld_resp_data  (ld_resp_data),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .fwd_a_data    (fwd_a_data),
        .fwd_b_data    (fwd_b_data),
        .stall         (stall),
        .flush         (flush)
`ifdef X_HAZARD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic             v;
        logic [31:0]      inst;
        logic [31:0]      res;
        logic             redir;
        logic             lrv;
        logic [31:0]      lrd;
        logic [SEL_W-1:0] as;
        logic [SEL_W-1:0] bs;
        logic [31:0]      ad;
        logic [31:0]      bd;
        logic             st;
        logic             fl;
    } vec_t;

    vec_t tbl[$];

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(int rd, int rs1, int rs2, int f7);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(int rd, int rs1, int imm, int f3, int opc);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
    endfunction
    function automatic logic [31:0] add_i(int rd, int rs1, int rs2);
        return enc_r(rd, rs1, rs2, 0);
    endfunction
    function automatic logic [31:0] sub_i(int rd, int rs1, int rs2);
        return enc_r(rd, rs1, rs2, 32);
    endfunction
    function automatic logic [31:0] addi_i(int rd, int rs1, int imm);
        return enc_i(rd, rs1, imm, 0, 7'b0010011);
    endfunction
    function automatic logic [31:0] lw_i(int rd, int rs1);
        return enc_i(rd, rs1, 0, 2, 7'b0000011);
    endfunction
    function automatic logic [31:0] jalr_i(int rd, int rs1);
        return enc_i(rd, rs1, 0, 0, 7'b1100111);
    endfunction
    function automatic logic [31:0] csr_i(int rd, int rs1, int f3);
        return enc_i(rd, rs1, 12'h300, f3, 7'b1110011);
    endfunction
    function automatic logic [31:0] jal_i(int rd);
        return {20'h0, 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] beq_i(int rs1, int rs2);
        return {7'h0, 5'(rs2), 5'(rs1), 3'b000, 5'h0, 7'b1100011};
    endfunction

    function automatic vec_t mk(int v, logic [31:0] inst, logic [31:0] res, int redir,
                                int lrv, logic [31:0] lrd, int as, int bs,
                                logic [31:0] ad, logic [31:0] bd, int st, int fl);
        vec_t r;
        r.v = v[0];     r.inst = inst;  r.res = res;  r.redir = redir[0];
        r.lrv = lrv[0]; r.lrd = lrd;    r.as = SEL_W'(as); r.bs = SEL_W'(bs);
        r.ad = ad;      r.bd = bd;      r.st = st[0]; r.fl = fl[0];
        return r;
    endfunction

    function automatic vec_t bub();
        return mk(0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        x_valid       = r.v;
        x_inst        = r.inst;
        x_result      = r.res;
        redirect      = r.redir;
        ld_resp_valid = r.lrv;
        ld_resp_data  = r.lrd;
    endtask

    task automatic chk_all(input string tag, input vec_t r);
        chk({tag, " a_sel"},  32'(fwd_a_sel), 32'(r.as));
        chk({tag, " b_sel"},  32'(fwd_b_sel), 32'(r.bs));
        chk({tag, " a_data"}, fwd_a_data,     r.ad);
        chk({tag, " b_data"}, fwd_b_data,     r.bd);
        chk({tag, " stall"},  32'(stall),     32'(r.st));
        chk({tag, " flush"},  32'(flush),     32'(r.fl));
    endtask

    initial begin
        // Columns: v, inst, result, redirect, ld_resp_valid, ld_resp_data,
        //          exp a_sel, b_sel, a_data, b_data, stall, flush
        // Basic forwarding, rs1 == rs2
        tbl.push_back(mk(1, addi_i(1, 0, 5), 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, add_i(2, 1, 1), 10, 0, 0, 0, 1, 1, 5, 5, 0, 0));
        tbl.push_back(bub());
        tbl.push_back(bub());
        // Youngest wins, then distance 2 through a bubble
        tbl.push_back(mk(1, addi_i(3, 0, 7), 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, addi_i(3, 0, 9), 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, sub_i(4, 3, 0), 9, 0, 0, 0, 1, 0, 9, 0, 0, 0));
        tbl.push_back(mk(1, addi_i(3, 0, 11), 11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(bub());
        tbl.push_back(mk(1, sub_i(4, 3, 0), 2, 0, 0, 0, 2, 0, 11, 0, 0, 0));
        tbl.push_back(bub());
        tbl.push_back(bub());
        // Load-use, response one cycle late: one stall cycle, then entry 1
        tbl.push_back(mk(1, lw_i(5, 0), 32'h123, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, add_i(6, 5, 0), 32'h1111, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, add_i(6, 5, 0), 32'h1111, 0, 1, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(bub());
        tbl.push_back(bub());
        // Load-use, response in the consumer cycle; resolved data kept in history
        tbl.push_back(mk(1, lw_i(7, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, add_i(8, 7, 7), 32'h11, 0, 1, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0));
        tbl.push_back(mk(1, add_i(9, 7, 0), 0, 0, 0, 0, 2, 0, 32'hCAFEF00D, 0, 0, 0));
        tbl.push_back(bub());
        tbl.push_back(bub());
        // Redirect: two flush cycles, second redirect ignored and not pushed
        tbl.push_back(mk(1, jal_i(1), 32'h100, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, jal_i(10), 32'h200, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, add_i(11, 10, 1), 5, 0, 0, 0, 0, 2, 0, 32'h100, 0, 0));
        tbl.push_back(bub());
        tbl.push_back(bub());
        // x0 never written or matched; CSR rs1 usage by funct3
        tbl.push_back(mk(1, add_i(0, 1, 1), 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, add_i(12, 0, 0), 32'h66, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, csr_i(13, 12, 2), 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, csr_i(14, 12, 1), 32'h0, 0, 0, 0, 2, 0, 32'h66, 0, 0, 0));
        // Pending load shifted out unresolved: late response ignored
        tbl.push_back(mk(1, lw_i(20, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(bub());
        tbl.push_back(bub());
        tbl.push_back(mk(1, add_i(21, 20, 0), 32'h21, 0, 1, 32'hBAD, 0, 0, 0, 0, 0, 0));
        tbl.push_back(bub());
        tbl.push_back(bub());
        // Redirect during stall is ignored, accepted once the load resolves
        tbl.push_back(mk(1, lw_i(22, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, jalr_i(23, 22), 32'h300, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, jalr_i(23, 22), 32'h300, 1, 1, 32'h400, 2, 0, 32'h400, 0, 0, 1));
        tbl.push_back(bub());
        tbl.push_back(bub());
        tbl.push_back(bub());
        // Branch uses rs2
        tbl.push_back(mk(1, addi_i(24, 0, 0), 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, beq_i(0, 24), 0, 0, 0, 0, 0, 1, 0, 32'h77, 0, 0));
        tbl.push_back(bub());

        // Fix up the flush tail row: the cycle after an accepted redirect still flushes.
        tbl[40].fl = 1'b1;

        // ---------------- reset state ----------------
        reset_n = 1'b0;
        drive(bub());
        #12;
        chk_all("reset", bub());
`ifdef X_HAZARD_PERF_EN
        chk("reset perf_stall", perf_stall_cnt, 32'd0);
        chk("reset perf_flush", perf_flush_cnt, 32'd0);
`endif
        #5 reset_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), tbl[i]);
        end

`ifdef X_HAZARD_PERF_EN
        @(posedge clk);
        #1;
        drive(bub());
        @(negedge clk);
        chk("perf_stall_cnt", perf_stall_cnt, 32'd2);
        chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

        // ---------------- reset in the middle of a flush ----------------
        @(posedge clk);
        #1;
        drive(mk(1, jal_i(25), 32'h500, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("mid_flush t flush", 32'(flush), 32'd1);
        @(posedge clk);
        #1;
        drive(bub());
        @(negedge clk);
        chk("mid_flush t+1 flush", 32'(flush), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("in_reset flush", 32'(flush), 32'd0);
        chk("in_reset stall", 32'(stall), 32'd0);
        chk("in_reset a_sel", 32'(fwd_a_sel), 32'd0);
`ifdef X_HAZARD_PERF_EN
        chk("in_reset perf_flush", perf_flush_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(mk(1, add_i(26, 25, 25), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        // x25 would sit in entry 1 had the history survived reset
        chk("post_reset a_sel", 32'(fwd_a_sel), 32'd0);
        chk("post_reset b_sel", 32'(fwd_b_sel), 32'd0);
        chk("post_reset flush", 32'(flush), 32'd0);

        @(posedge clk);
        #1;
        drive(bub());
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
